// File: rtl/mprj_io_cfg_loader.sv
// rtl/mprj_io_cfg_loader.sv - serialises per-pad config words into the pad control chain
// Optional readback CRC of the chain tail is built when MPRJ_CFG_READBACK_EN is defined.
module mprj_io_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4,
  localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic [AW-1:0]       cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_data,
`ifdef MPRJ_CFG_READBACK_EN
  input  logic                serial_data_in,
  output logic [15:0]         readback_crc,
`endif
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load,
  output logic                busy,
  output logic                done
);

  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t              state;
  logic [BW-1:0]       bit_cnt;
  logic [DW-1:0]       div_cnt;
  logic [CFG_BITS-1:0] shift_reg;
  logic [CFG_BITS-1:0] shift_next;
  logic                div_last;

  // cfg_addr doubles as the pad counter: it is the fetch address in FETCH and
  // naturally holds its value (ending at 0) everywhere else.
  assign div_last   = (div_cnt == DIV_LAST);
  assign shift_next = shift_reg << 1;

  // Transfer sequencer; all pad-facing outputs are registered alongside the state
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      cfg_addr        <= '0;
      bit_cnt         <= '0;
      div_cnt         <= '0;
      shift_reg       <= '0;
      serial_clock    <= 1'b0;
      serial_data_out <= 1'b0;
      serial_load     <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            cfg_addr <= LAST_PAD;
            div_cnt  <= '0;
            busy     <= 1'b1;
          end
        end

        ST_FETCH: begin
          shift_reg       <= cfg_data;
          bit_cnt         <= LAST_BIT;
          div_cnt         <= '0;
          serial_data_out <= cfg_data[CFG_BITS-1];
          state           <= ST_SHIFT_LO;
        end

        ST_SHIFT_LO: begin
          if (div_last) begin
            div_cnt      <= '0;
            serial_clock <= 1'b1;
            state        <= ST_SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        ST_SHIFT_HI: begin
          if (div_last) begin
            div_cnt      <= '0;
            serial_clock <= 1'b0;
            shift_reg    <= shift_next;
            if (bit_cnt != '0) begin
              bit_cnt         <= bit_cnt - BW'(1);
              serial_data_out <= shift_next[CFG_BITS-1];
              state           <= ST_SHIFT_LO;
            end else if (cfg_addr != '0) begin
              cfg_addr <= cfg_addr - AW'(1);
              state    <= ST_FETCH;
            end else begin
              serial_data_out <= 1'b0;
              serial_load     <= 1'b1;
              state           <= ST_LOAD;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        ST_LOAD: begin
          if (div_last) begin
            div_cnt     <= '0;
            serial_load <= 1'b0;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          serial_clock <= 1'b0;
          serial_load  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MPRJ_CFG_READBACK_EN
  // CRC-16-CCITT single-bit step, MSB-first, poly 0x1021
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Fold the chain tail into the CRC on the last low cycle, just before serial_clock rises
  always_ff @(posedge clock) begin
    if (reset) begin
      readback_crc <= 16'hFFFF;
    end else if (state == ST_IDLE && start) begin
      readback_crc <= 16'hFFFF;
    end else if (state == ST_SHIFT_LO && div_last) begin
      readback_crc <= crc16_step(readback_crc, serial_data_in);
    end
  end
`endif

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb/tb_mprj_io_cfg_loader.sv - self-checking bench for mprj_io_cfg_loader
module tb_mprj_io_cfg_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rst;
  logic [2:0] start;
  logic [2:0] sdi;
  wire  [2:0] sclk;
  wire  [2:0] sdo;
  wire  [2:0] sload;
  wire  [2:0] busy;
  wire  [2:0] done;
  wire  [0:0] addr0;
  wire  [5:0] addr1;
  wire  [0:0] addr2;
  wire  [3:0] data0;
  wire  [12:0] data1;
  wire  [7:0] data2;
`ifdef MPRJ_CFG_READBACK_EN
  wire  [15:0] crc0;
  wire  [15:0] crc1;
  wire  [15:0] crc2;
`endif

  logic [12:0] mem [3][38];

  assign data0 = mem[0][addr0][3:0];
  assign data1 = mem[1][addr1];
  assign data2 = mem[2][addr2][7:0];

  mprj_io_cfg_loader #(.NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1)) u_small (
    .clock(clock), .reset(rst[0]), .start(start[0]),
    .cfg_addr(addr0), .cfg_data(data0),
`ifdef MPRJ_CFG_READBACK_EN
    .serial_data_in(sdi[0]), .readback_crc(crc0),
`endif
    .serial_clock(sclk[0]), .serial_data_out(sdo[0]), .serial_load(sload[0]),
    .busy(busy[0]), .done(done[0])
  );

  mprj_io_cfg_loader u_dut (
    .clock(clock), .reset(rst[1]), .start(start[1]),
    .cfg_addr(addr1), .cfg_data(data1),
`ifdef MPRJ_CFG_READBACK_EN
    .serial_data_in(sdi[1]), .readback_crc(crc1),
`endif
    .serial_clock(sclk[1]), .serial_data_out(sdo[1]), .serial_load(sload[1]),
    .busy(busy[1]), .done(done[1])
  );

  mprj_io_cfg_loader #(.NUM_PADS(1), .CFG_BITS(8), .CLK_DIV(3)) u_div3 (
    .clock(clock), .reset(rst[2]), .start(start[2]),
    .cfg_addr(addr2), .cfg_data(data2),
`ifdef MPRJ_CFG_READBACK_EN
    .serial_data_in(sdi[2]), .readback_crc(crc2),
`endif
    .serial_clock(sclk[2]), .serial_data_out(sdo[2]), .serial_load(sload[2]),
    .busy(busy[2]), .done(done[2])
  );

  typedef struct {
    int inst;
    int fill;       // 0 random, 1 all ones, 2 pad1=0xA pad0=0x3
    int rs1;
    int rs2;
    int exp_lat;
    int exp_edges;
    int exp_load;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int np(input int i);
    return (i == 0) ? 2 : (i == 1) ? 38 : 1;
  endfunction
  function automatic int cb(input int i);
    return (i == 0) ? 4 : (i == 1) ? 13 : 8;
  endfunction
  function automatic int cd(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 3;
  endfunction
  function automatic int get_addr(input int i);
    case (i)
      0:       return int'(addr0);
      1:       return int'(addr1);
      default: return int'(addr2);
    endcase
  endfunction

  function automatic logic rb_bit(input int k);
    logic [7:0] w;
    w = 8'h31;
    return w[7 - (k % 8)];
  endfunction

`ifdef MPRJ_CFG_READBACK_EN
  function automatic logic [15:0] crc_model(input int nbits);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < nbits; k++) begin
      fb = c[15] ^ rb_bit(k);
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
  function automatic int get_crc(input int i);
    case (i)
      0:       return int'(crc0);
      1:       return int'(crc1);
      default: return int'(crc2);
    endcase
  endfunction
`endif

  task automatic run_case(input vec_t v);
    int i, edges, mism, load_cyc, load_pulses, last_load, done_cnt, done_n;
    int bad_sdo, bad_hi, bad_lo, bad_busy, run, last_addr, a, nmin;
    logic s, ps, psdo, pload, seen_hi;
    logic [7:0] packed8;
    logic [12:0] mask;
    int exp_bits[$];
    int got_bits[$];
    int addr_seq[$];
    i = v.inst;
    mask = 13'((1 << cb(i)) - 1);
    for (int p = 0; p < np(i); p++) begin
      case (v.fill)
        0:       mem[i][p] = 13'($urandom) & mask;
        1:       mem[i][p] = mask;
        default: mem[i][p] = (p == 1) ? 13'h00A : 13'h003;
      endcase
    end
    for (int p = np(i) - 1; p >= 0; p--)
      for (int b = cb(i) - 1; b >= 0; b--)
        exp_bits.push_back(int'(mem[i][p][b]));

    edges = 0; load_cyc = 0; load_pulses = 0; last_load = -100; done_cnt = 0; done_n = -1;
    bad_sdo = 0; bad_hi = 0; bad_lo = 0; bad_busy = 0; run = 0;
    ps = 1'b0; pload = 1'b0; seen_hi = 1'b0;
    psdo = sdo[i];
    last_addr = get_addr(i);

    @(negedge clock);
    start[i] = 1'b1;
    sdi[i] = rb_bit(0);
    for (int n = 1; n <= v.exp_lat + 40; n++) begin
      @(negedge clock);
      start[i] = (n == v.rs1) || (n == v.rs2);
      s = sclk[i];
      if (s && !ps) begin
        edges++;
        got_bits.push_back(int'(sdo[i]));
      end
      if (s && (sdo[i] != psdo)) bad_sdo++;
      if (s == ps) run++;
      else begin
        if (ps) begin
          if (run != cd(i)) bad_hi++;
          seen_hi = 1'b1;
        end else if (seen_hi && i == 2 && run != cd(i)) bad_lo++;
        run = 1;
      end
      ps = s;
      psdo = sdo[i];
      if (sload[i]) begin
        load_cyc++;
        last_load = n;
        if (!pload) load_pulses++;
      end
      pload = sload[i];
      if (done[i]) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (busy[i] != ((done_n < 0) || (n == done_n))) bad_busy++;
      a = get_addr(i);
      if (busy[i] && a != last_addr) begin
        addr_seq.push_back(a);
        last_addr = a;
      end
      sdi[i] = rb_bit(edges);
`ifdef MPRJ_CFG_READBACK_EN
      if (n == done_n) chk("crc_at_done", get_crc(i), crc_model(np(i) * cb(i)));
`endif
      if (done_n >= 0 && n >= done_n + 2) break;
    end
    start[i] = 1'b0;

    mism = (exp_bits.size() > got_bits.size()) ? exp_bits.size() - got_bits.size()
                                                : got_bits.size() - exp_bits.size();
    nmin = (exp_bits.size() < got_bits.size()) ? exp_bits.size() : got_bits.size();
    for (int k = 0; k < nmin; k++)
      if (exp_bits[k] != got_bits[k]) mism++;

    chk("latency", done_n, v.exp_lat);
    chk("edges", edges, v.exp_edges);
    chk("bit_stream_mismatches", mism, 0);
    chk("load_cycles", load_cyc, v.exp_load);
    chk("load_pulses", load_pulses, 1);
    chk("done_cycles", done_cnt, 1);
    chk("done_after_load", done_n - last_load, 1);
    chk("busy_profile_errors", bad_busy, 0);
    chk("busy_after", int'(busy[i]), 0);
    chk("addr_after", get_addr(i), 0);
    chk("sdo_change_while_high", bad_sdo, 0);
    chk("high_phase_errors", bad_hi, 0);
    if (i == 2) chk("low_phase_errors", bad_lo, 0);
    if (i == 0) begin
      chk("addr_seq_len", addr_seq.size(), 2);
      chk("addr_seq_first", (addr_seq.size() > 0) ? addr_seq[0] : -1, 1);
      chk("addr_seq_second", (addr_seq.size() > 1) ? addr_seq[1] : -1, 0);
    end
    if (v.fill == 2) begin
      packed8 = '0;
      for (int k = 0; k < 8 && k < got_bits.size(); k++)
        packed8 = {packed8[6:0], 1'(got_bits[k])};
      chk("pattern_A3", packed8, 8'hA3);
    end
`ifdef MPRJ_CFG_READBACK_EN
    chk("crc_held", get_crc(i), crc_model(np(i) * cb(i)));
`endif
  endtask

  vec_t vecs[6];

  initial begin
    int found, load_seen;
    vecs[0] = '{0, 2, -1, -1, 20, 8, 1};
    vecs[1] = '{0, 0, -1, -1, 20, 8, 1};
    vecs[2] = '{1, 1, -1, -1, 3995, 494, 4};
    vecs[3] = '{1, 0, 10, 500, 3995, 494, 4};
    vecs[4] = '{2, 0, -1, -1, 53, 8, 3};
    vecs[5] = '{2, 1, -1, -1, 53, 8, 3};

    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 38; p++)
        mem[i][p] = '0;
    rst = 3'b111;
    start = 3'b000;
    sdi = 3'b000;
    repeat (3) @(negedge clock);
    chk("reset_sclk", sclk, 0);
    chk("reset_sdo", sdo, 0);
    chk("reset_load", sload, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_addr", get_addr(0) + get_addr(1) + get_addr(2), 0);
`ifdef MPRJ_CFG_READBACK_EN
    chk("reset_crc", get_crc(1), 16'hFFFF);
`endif
    rst = 3'b000;
    @(negedge clock);

    rst[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clock);
    chk("reset_beats_start_busy", int'(busy[0]), 0);
    rst[0] = 1'b0;
    start[0] = 1'b0;
    @(negedge clock);
    chk("reset_beats_start_idle", int'(busy[0]), 0);

    for (int t = 0; t < 6; t++) run_case(vecs[t]);

    for (int p = 0; p < 38; p++) mem[1][p] = 13'($urandom);
    found = 0;
    load_seen = 0;
    @(negedge clock);
    start[1] = 1'b1;
    @(negedge clock);
    start[1] = 1'b0;
    for (int n = 0; n < 4000 && found == 0; n++) begin
      @(negedge clock);
      if (sload[1]) load_seen++;
      if (get_addr(1) == 20) found = 1;
    end
    chk("reached_pad20", found, 1);
    repeat (30) begin
      @(negedge clock);
      if (sload[1]) load_seen++;
    end
    rst[1] = 1'b1;
    @(negedge clock);
    chk("abort_sclk", int'(sclk[1]), 0);
    chk("abort_sdo", int'(sdo[1]), 0);
    chk("abort_load", int'(sload[1]), 0);
    chk("abort_busy", int'(busy[1]), 0);
    chk("abort_done", int'(done[1]), 0);
    chk("abort_addr", get_addr(1), 0);
    rst[1] = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (sload[1] || busy[1]) load_seen++;
    end
    chk("abort_no_load", load_seen, 0);

    run_case('{1, 0, -1, -1, 3995, 494, 4});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
